// File: rtl/reg_trace_monitor.sv
// Register trace monitor: captures per-channel value changes with a timestamp into a trace FIFO.
// Optional macro REG_TRACE_DROP_CNT_EN enables the saturating lost-event counter on drop_cnt.
module reg_trace_monitor #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ENTRY_W = CH_W + TS_W + DATA_W,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [LVL_W-1:0]         level,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TS_W-1:0]    ts;
  logic [DATA_W-1:0]  shadow   [NUM_CH];
  logic [NUM_CH-1:0]  pending;
  logic [DATA_W-1:0]  pend_val [NUM_CH];
  logic [TS_W-1:0]    pend_ts  [NUM_CH];
  logic [ENTRY_W-1:0] mem      [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   cnt;

  logic [NUM_CH-1:0]  det;
  logic [NUM_CH-1:0]  drain;
  logic [ENTRY_W-1:0] wr_entry;
  logic               sel_found;
  logic               full;
  logic               rd_hs;
  logic               wr_en;

  // Read port: an entry transfers on a rising edge where rd_valid and rd_ready are both 1;
  // rd_data holds the oldest entry while rd_valid is 1, and rd_ready is ignored otherwise.
  assign rd_valid = (cnt != '0);
  assign full     = (cnt == LVL_W'(DEPTH));
  assign rd_hs    = rd_valid & rd_ready;
  assign level    = cnt;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    det       = '0;
    drain     = '0;
    wr_entry  = '0;
    sel_found = 1'b0;
    wr_en     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      det[i] = arm && (ch_data[i*DATA_W +: DATA_W] != shadow[i]);
      if (pending[i] && !sel_found) begin
        sel_found = 1'b1;
        drain[i]  = 1'b1;
        wr_entry  = {CH_W'(i), pend_ts[i], pend_val[i]};
      end
    end
    // A full FIFO still accepts the write when the head leaves on the same edge.
    wr_en = sel_found && (!full || rd_hs);
    if (!wr_en) drain = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts      <= '0;
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i]   <= '0;
        pend_val[i] <= '0;
        pend_ts[i]  <= '0;
      end
    end else begin
      ts <= ts + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (arm) shadow[i] <= ch_data[i*DATA_W +: DATA_W];
        // A fresh change wins over the drain so the newer event stays pending.
        if (det[i]) begin
          pending[i]  <= 1'b1;
          pend_val[i] <= ch_data[i*DATA_W +: DATA_W];
          pend_ts[i]  <= ts;
        end else if (drain[i]) begin
          pending[i]  <= 1'b0;
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr] <= wr_entry;
  end

`ifdef REG_TRACE_DROP_CNT_EN
  logic [16:0] drop_sum;
  logic [15:0] drop_q;

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_CH; i++) begin
      if (det[i] && pending[i] && !drain[i]) drop_sum = drop_sum + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
